// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB stage; runs the data-memory req/ack access (word load, store, vector burst)
// and registers the scalar or vector writeback, stalling EX/MEM while an access is outstanding.
module mem_wb_stage #(
  parameter int VEC_WORDS = 4,
  parameter int RD_W      = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    MEM_Valid,
  input  logic [31:0]             MEM_ALUResult,
  input  logic [31:0]             MEM_WriteData,
  input  logic [RD_W-1:0]         MEM_rd,
  input  logic                    MEM_RegWrite,
  input  logic                    MEM_VRegWrite,
  input  logic                    MEM_MemWrite,
  input  logic [1:0]              MEM_MemToReg,
  output logic                    mem_stall,
  output logic                    dmem_req,
  output logic                    dmem_we,
  output logic [31:0]             dmem_addr,
  output logic [31:0]             dmem_wdata,
  input  logic                    dmem_ack,
  input  logic [31:0]             dmem_rdata,
  output logic [RD_W-1:0]         WB_rd,
  output logic [31:0]             WB_Data,
  output logic                    WB_RegWrite,
  output logic [32*VEC_WORDS-1:0] WB_VData,
  output logic                    WB_VRegWrite
);
  localparam int CW = VEC_WORDS > 1 ? $clog2(VEC_WORDS) : 1;
  localparam int VW = 32 * VEC_WORDS;
  typedef enum logic [1:0] {IDLE, ACCESS, BURST} state_e;
  state_e          state_q, state_d;
  logic            req_q, req_d, we_q, we_d;
  logic [31:0]     addr_q, addr_d, wdata_q, wdata_d, wb_data_q, wb_data_d;
  logic [RD_W-1:0] rd_q, rd_d, wb_rd_q, wb_rd_d;
  logic            regw_q, regw_d, vregw_q, vregw_d;
  logic            wb_regw_q, wb_regw_d, wb_vregw_q, wb_vregw_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [VW-1:0]   vbuf_q, vbuf_d, wb_vdata_q, wb_vdata_d, lanes;
  logic            ack, last, needs_mem;
  assign ack       = dmem_ack & req_q;
  assign last      = cnt_q == CW'(VEC_WORDS - 1);
  assign needs_mem = MEM_MemWrite | (MEM_MemToReg == 2'b01) | (MEM_MemToReg == 2'b10);
  assign mem_stall = (state_q == IDLE & MEM_Valid & needs_mem)
                   | (state_q == ACCESS & !ack)
                   | (state_q == BURST & !(ack & last));
  always_comb begin
    lanes = vbuf_q;
    lanes[cnt_q*32 +: 32] = dmem_rdata;
  end
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    regw_d     = regw_q;
    vregw_d    = vregw_q;
    cnt_d      = cnt_q;
    vbuf_d     = vbuf_q;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    wb_vdata_d = wb_vdata_q;
    wb_regw_d  = 1'b0;
    wb_vregw_d = 1'b0;
    case (state_q)
      IDLE: if (MEM_Valid) begin
        if (needs_mem) begin
          req_d   = 1'b1;
          we_d    = MEM_MemWrite;
          addr_d  = MEM_ALUResult & ~32'h3;
          wdata_d = MEM_WriteData;
          rd_d    = MEM_rd;
          regw_d  = MEM_RegWrite;
          vregw_d = MEM_VRegWrite;
          cnt_d   = '0;
          state_d = (!MEM_MemWrite && MEM_MemToReg == 2'b10) ? BURST : ACCESS;
        end else begin
          wb_data_d = MEM_ALUResult;
          wb_rd_d   = MEM_rd;
          wb_regw_d = MEM_RegWrite & (MEM_rd != '0);
        end
      end
      ACCESS: if (ack) begin
        req_d   = 1'b0;
        we_d    = 1'b0;
        state_d = IDLE;
        if (!we_q) begin
          wb_data_d = dmem_rdata;
          wb_rd_d   = rd_q;
          wb_regw_d = regw_q & (rd_q != '0);
        end
      end
      BURST: if (ack) begin
        vbuf_d = lanes;
        if (last) begin
          req_d      = 1'b0;
          state_d    = IDLE;
          wb_vdata_d = lanes;
          wb_rd_d    = rd_q;
          wb_vregw_d = vregw_q;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          addr_d = addr_q + 32'd4;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      regw_q     <= 1'b0;
      vregw_q    <= 1'b0;
      cnt_q      <= '0;
      vbuf_q     <= '0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_vdata_q <= '0;
      wb_regw_q  <= 1'b0;
      wb_vregw_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      regw_q     <= regw_d;
      vregw_q    <= vregw_d;
      cnt_q      <= cnt_d;
      vbuf_q     <= vbuf_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      wb_vdata_q <= wb_vdata_d;
      wb_regw_q  <= wb_regw_d;
      wb_vregw_q <= wb_vregw_d;
    end
  end
  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign WB_rd        = wb_rd_q;
  assign WB_Data      = wb_data_q;
  assign WB_RegWrite  = wb_regw_q;
  assign WB_VData     = wb_vdata_q;
  assign WB_VRegWrite = wb_vregw_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed checks of mem_wb_stage; inputs change and outputs are sampled on negedge.
module tb_mem_wb_stage;
  logic         clk = 1'b0, rst_n;
  logic         MEM_Valid, MEM_RegWrite, MEM_VRegWrite, MEM_MemWrite;
  logic [31:0]  MEM_ALUResult, MEM_WriteData, dmem_addr, dmem_wdata, dmem_rdata, WB_Data;
  logic [4:0]   MEM_rd, WB_rd;
  logic [1:0]   MEM_MemToReg;
  logic         mem_stall, dmem_req, dmem_we, dmem_ack, WB_RegWrite, WB_VRegWrite;
  logic [127:0] WB_VData;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  mem_wb_stage #(.VEC_WORDS(4), .RD_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .MEM_Valid(MEM_Valid), .MEM_ALUResult(MEM_ALUResult),
    .MEM_WriteData(MEM_WriteData), .MEM_rd(MEM_rd), .MEM_RegWrite(MEM_RegWrite),
    .MEM_VRegWrite(MEM_VRegWrite), .MEM_MemWrite(MEM_MemWrite), .MEM_MemToReg(MEM_MemToReg),
    .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .WB_rd(WB_rd),
    .WB_Data(WB_Data), .WB_RegWrite(WB_RegWrite), .WB_VData(WB_VData), .WB_VRegWrite(WB_VRegWrite)
  );
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [31:0] alu, input logic [4:0] rd, input logic rw, input logic vrw,
                       input logic mw, input logic [1:0] m2r, input logic [31:0] wd);
    MEM_Valid = 1'b1; MEM_ALUResult = alu; MEM_rd = rd; MEM_RegWrite = rw;
    MEM_VRegWrite = vrw; MEM_MemWrite = mw; MEM_MemToReg = m2r; MEM_WriteData = wd;
  endtask
  initial begin
    rst_n = 1'b0; MEM_Valid = 1'b0; MEM_ALUResult = '0; MEM_WriteData = '0; MEM_rd = '0;
    MEM_RegWrite = 1'b0; MEM_VRegWrite = 1'b0; MEM_MemWrite = 1'b0; MEM_MemToReg = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_wbrw", WB_RegWrite, 1'b0);
    chk("rst_wbdata", WB_Data, 32'h0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_stall", mem_stall, 1'b0);
    rst_n = 1'b1;
    issue(32'hAA, 5'd3, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0);
    #1 chk("alu_stall", mem_stall, 1'b0);
    @(negedge clk); MEM_Valid = 1'b0;
    chk("alu_wbrw", WB_RegWrite, 1'b1);
    chk("alu_wbdata", WB_Data, 32'hAA);
    chk("alu_wbrd", WB_rd, 5'd3);
    chk("alu_stall2", mem_stall, 1'b0);
    dmem_ack = 1'b1;
    @(negedge clk); dmem_ack = 1'b0;
    chk("alu_pulse_end", WB_RegWrite, 1'b0);
    chk("alu_hold", WB_Data, 32'hAA);
    chk("stray_ack_req", dmem_req, 1'b0);
    issue(32'h77, 5'd4, 1'b1, 1'b0, 1'b0, 2'b11, 32'h0);
    #1 chk("m11_stall", mem_stall, 1'b0);
    @(negedge clk); MEM_Valid = 1'b0;
    chk("m11_wbdata", WB_Data, 32'h77);
    chk("m11_wbrw", WB_RegWrite, 1'b1);
    chk("m11_req", dmem_req, 1'b0);
    @(negedge clk);
    issue(32'h103, 5'd5, 1'b0, 1'b0, 1'b1, 2'b01, 32'hDEADBEEF);
    #1 chk("st_stall0", mem_stall, 1'b1);
    @(negedge clk);
    chk("st_req1", dmem_req, 1'b1);
    chk("st_we", dmem_we, 1'b1);
    chk("st_addr", dmem_addr, 32'h100);
    chk("st_wdata", dmem_wdata, 32'hDEADBEEF);
    chk("st_stall1", mem_stall, 1'b1);
    @(negedge clk);
    chk("st_req2", dmem_req, 1'b1);
    chk("st_stall2", mem_stall, 1'b1);
    @(negedge clk);
    chk("st_req3", dmem_req, 1'b1);
    dmem_ack = 1'b1;
    #1 chk("st_stall3", mem_stall, 1'b0);
    @(negedge clk); dmem_ack = 1'b0; MEM_Valid = 1'b0; MEM_MemWrite = 1'b0;
    chk("st_req_done", dmem_req, 1'b0);
    chk("st_no_wb", WB_RegWrite, 1'b0);
    chk("st_no_vwb", WB_VRegWrite, 1'b0);
    chk("st_wb_hold", WB_Data, 32'h77);
    issue(32'h40, 5'd7, 1'b1, 1'b0, 1'b0, 2'b01, 32'h0);
    #1 chk("ld_stall0", mem_stall, 1'b1);
    @(negedge clk);
    chk("ld_req", dmem_req, 1'b1);
    chk("ld_we", dmem_we, 1'b0);
    chk("ld_addr", dmem_addr, 32'h40);
    dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
    #1 chk("ld_stall_ack", mem_stall, 1'b0);
    @(negedge clk); dmem_ack = 1'b0;
    issue(32'h55, 5'd9, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0);
    chk("ld_wbrw", WB_RegWrite, 1'b1);
    chk("ld_wbdata", WB_Data, 32'h12345678);
    chk("ld_wbrd", WB_rd, 5'd7);
    chk("ld_req_done", dmem_req, 1'b0);
    #1 chk("ld_next_stall", mem_stall, 1'b0);
    @(negedge clk); MEM_Valid = 1'b0;
    chk("ld_next_wbdata", WB_Data, 32'h55);
    chk("ld_next_wbrd", WB_rd, 5'd9);
    @(negedge clk);
    chk("ld_pulse_end", WB_RegWrite, 1'b0);
    issue(32'hFFFF_FFF8, 5'd2, 1'b0, 1'b1, 1'b0, 2'b10, 32'h0);
    @(negedge clk);
    chk("vl_req", dmem_req, 1'b1);
    chk("vl_we", dmem_we, 1'b0);
    chk("vl_addr0", dmem_addr, 32'hFFFF_FFF8);
    dmem_ack = 1'b1; dmem_rdata = 32'h0;
    #1 chk("vl_stall0", mem_stall, 1'b1);
    @(negedge clk);
    chk("vl_addr1", dmem_addr, 32'hFFFF_FFFC);
    chk("vl_vdata_hold", WB_VData, 128'h0);
    dmem_rdata = 32'h1;
    #1 chk("vl_stall1", mem_stall, 1'b1);
    @(negedge clk);
    chk("vl_addr2", dmem_addr, 32'h0);
    dmem_rdata = 32'h2;
    @(negedge clk);
    chk("vl_addr3", dmem_addr, 32'h4);
    chk("vl_req3", dmem_req, 1'b1);
    dmem_rdata = 32'h3;
    #1 chk("vl_stall_last", mem_stall, 1'b0);
    @(negedge clk); dmem_ack = 1'b0; MEM_Valid = 1'b0;
    chk("vl_vwb", WB_VRegWrite, 1'b1);
    chk("vl_vdata", WB_VData, 128'h00000003_00000002_00000001_00000000);
    chk("vl_wbrw", WB_RegWrite, 1'b0);
    chk("vl_req_done", dmem_req, 1'b0);
    @(negedge clk);
    chk("vl_pulse_end", WB_VRegWrite, 1'b0);
    issue(32'h80, 5'd0, 1'b1, 1'b0, 1'b0, 2'b01, 32'h0);
    @(negedge clk);
    chk("x0_req", dmem_req, 1'b1);
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
    @(negedge clk); dmem_ack = 1'b0; MEM_Valid = 1'b0;
    chk("x0_wbdata", WB_Data, 32'hCAFEF00D);
    chk("x0_wbrw", WB_RegWrite, 1'b0);
    @(negedge clk);
    issue(32'h200, 5'd6, 1'b0, 1'b1, 1'b0, 2'b10, 32'h0);
    @(negedge clk); dmem_ack = 1'b1; dmem_rdata = 32'h7;
    @(negedge clk); dmem_rdata = 32'h8;
    @(negedge clk);
    chk("rb_addr2", dmem_addr, 32'h208);
    rst_n = 1'b0; dmem_rdata = 32'h9;
    @(negedge clk); rst_n = 1'b1; dmem_ack = 1'b0; MEM_Valid = 1'b0;
    chk("rb_req", dmem_req, 1'b0);
    chk("rb_vwb", WB_VRegWrite, 1'b0);
    chk("rb_vdata", WB_VData, 128'h0);
    #1 chk("rb_stall", mem_stall, 1'b0);
    @(negedge clk);
    chk("rb_vwb2", WB_VRegWrite, 1'b0);
    chk("rb_req2", dmem_req, 1'b0);
    issue(32'h33, 5'd1, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0);
    @(negedge clk); MEM_Valid = 1'b0;
    chk("rb_idle_alu", WB_Data, 32'h33);
    chk("rb_idle_wbrw", WB_RegWrite, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Consumer end of the EX/MEM pipeline register: takes the MEM_* bundle, performs the data-memory access over a req/ack handshake and produces registered writeback to the scalar or vector register file.
- Asserts a stall back to EX/MEM while a memory access is outstanding.
- Supports 32-bit load, 32-bit store and multi-word vector load (AES state block).

Parameters:
- VEC_WORDS, 4, number of 32-bit beats in a vector load; WB_VData width = 32*VEC_WORDS
- RD_W, 5, register index width

Ports:
- clk  input  1  pipeline clock; all state updates on posedge
- rst_n  input  1  reset, synchronous, active-low
- MEM_Valid  input  1  EX/MEM bundle holds a live instruction
- MEM_ALUResult  input  32  ALU result / memory byte address
- MEM_WriteData  input  32  store data
- MEM_rd  input  RD_W  destination register
- MEM_RegWrite  input  1  scalar writeback enable
- MEM_VRegWrite  input  1  vector writeback enable
- MEM_MemWrite  input  1  store
- MEM_MemToReg  input  2  00 ALU, 01 word load, 10 vector load, 11 reserved (treated as 00)
- mem_stall  output  1  combinational; EX/MEM must hold its outputs while high
- dmem_req  output  1  memory request, registered
- dmem_we  output  1  write enable, valid while dmem_req
- dmem_addr  output  32  word-aligned address (bits [1:0] forced 0)
- dmem_wdata  output  32  store data
- dmem_ack  input  1  beat complete; sampled only while dmem_req=1
- dmem_rdata  input  32  read data, valid with dmem_ack on reads
- WB_rd  output  RD_W  writeback index
- WB_Data  output  32  scalar writeback data
- WB_RegWrite  output  1  one-cycle scalar write pulse
- WB_VData  output  32*VEC_WORDS  vector writeback data; beat 0 in bits [31:0]
- WB_VRegWrite  output  1  one-cycle vector write pulse

Behaviour:
- States: IDLE, ACCESS (single load/store), BURST (vector load).
- Reset (rst_n=0 at posedge): state IDLE; dmem_req, dmem_we, WB_RegWrite, WB_VRegWrite = 0; dmem_addr, dmem_wdata, WB_Data, WB_VData, WB_rd, beat counter = 0. An outstanding access is abandoned and no writeback is issued. Overrides every other event in the same cycle.
- IDLE, MEM_Valid=0: nothing issued; WB pulses drop to 0.
- IDLE, MEM_Valid=1, ALU-only (MemWrite=0, MemToReg=00/11): next cycle WB_Data=MEM_ALUResult, WB_rd=MEM_rd, WB_RegWrite=MEM_RegWrite, WB_VRegWrite=0; no stall; latency 1.
- IDLE, MEM_Valid=1, MemWrite=1 (has priority over MemToReg): capture addr/data; next cycle dmem_req=1, dmem_we=1; go ACCESS. No writeback for stores.
- IDLE, MEM_Valid=1, MemToReg=01: dmem_req=1, dmem_we=0 next cycle; go ACCESS.
- IDLE, MEM_Valid=1, MemToReg=10: beat counter=0; dmem_req=1, dmem_we=0 next cycle; go BURST.
- ACCESS: hold req/addr/we/wdata until dmem_ack. On ack: dmem_req=0 next cycle; go IDLE. For loads, next cycle WB_Data=dmem_rdata, WB_rd, WB_RegWrite=captured RegWrite.
- BURST: on each ack, store dmem_rdata into lane[counter]. Non-final beat: counter+1, dmem_addr+4 (mod 2^32), req stays high. Final beat (counter=VEC_WORDS-1): dmem_req=0; next cycle WB_VData complete, WB_VRegWrite=captured VRegWrite, WB_RegWrite=0; go IDLE.
- Ack may arrive in the first cycle of req (zero wait). Ack while req=0 is ignored.
- mem_stall = (IDLE & MEM_Valid & needs_mem) | (ACCESS & !dmem_ack) | (BURST & !(dmem_ack & final beat)). Stall drops in the cycle of the final ack, so upstream advances on that edge and the same instruction is never re-accepted.
- WB_RegWrite is forced 0 when WB_rd=0 (x0 hardwired). Vector register 0 is writable.
- WB pulses last exactly one cycle. WB_Data, WB_VData and WB_rd hold their value until the next writeback.

Test Plan:
- ALU op ALUResult=0x0000_00AA, rd=3, RegWrite=1 -> next cycle WB_RegWrite=1, WB_Data=0xAA, WB_rd=3; mem_stall never high.
- Store addr=0x103, data=0xDEADBEEF, ack after 2 wait cycles -> dmem_addr=0x100, dmem_we=1; req high 3 cycles; mem_stall high 3 cycles; no WB pulse.
- Word load addr=0x40, rd=7, zero-wait ack, rdata=0x12345678 -> WB_Data=0x12345678, WB_rd=7, one pulse; a following ALU op is accepted on the next edge.
- Vector load addr=0xFFFF_FFF8, VRegWrite=1, rdata 0x0..0x3 -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, 0x4; WB_VData=0x00000003_00000002_00000001_00000000; WB_VRegWrite one pulse.
- Load with rd=0, RegWrite=1 -> access performed; WB_RegWrite stays 0.
- rst_n low during BURST beat 2 -> next cycle dmem_req=0, state IDLE, no WB pulse, mem_stall=0 with MEM_Valid=0.
